sd_cmd_sequencer: RTL and testbench
===================================

Name: sd_cmd_sequencer

Overview:
Command-line controller for the SD host. It takes a command latched from the command register (R00Eh) and argument register (R008h). It then serialises the 48-bit command frame with CRC7 onto the CMD pin, waits for and deserialises the card response, and reports status. Status goes to the present-state register (R024h CMD inhibit), the response register, and the error interrupt status register (R032h). It sits between the register file and the cmd_pin_in/cmd_pin_out pads.

Parameters:
TIMEOUT_TICKS, 64, SD ticks allowed between frame end bit and response start bit (NCR) before a timeout error.
NCC_TICKS, 8, idle SD ticks after the transaction ends before CMD inhibit clears.

Ports:
clock  in  1  system clock; all logic in this single domain.
reset  in  1  synchronous, active-low reset.
sd_tick  in  1  one-cycle strobe per SD bus clock; the CMD line advances or samples only on cycles with sd_tick=1.
cmd_start  in  1  one-cycle pulse when the CPU writes R00Eh.
cmd_index  in  6  command index (R00Eh[13:8]).
resp_type  in  2  00 none, 01 136-bit, 10 48-bit, 11 48-bit busy (treated as 48-bit).
crc_check_en  in  1  R00Eh[3].
index_check_en  in  1  R00Eh[4].
cmd_arg  in  32  argument (R008h).
cmd_pin_in  in  1  sampled CMD line.
cmd_pin_out  out  1  driven CMD line value.
cmd_oe  out  1  CMD output enable.
cmd_inhibit  out  1  R024h[0].
cmd_complete  out  1  one-cycle pulse.
response  out  128  R010h..R01Fh image.
err_status  out  4  [0] timeout, [1] CRC, [2] end bit, [3] index; sticky.
err_clear  in  4  write-1-to-clear for err_status.

Behaviour:
- Reset values (reset=0 at a clock edge): state IDLE, cmd_pin_out=1, cmd_oe=0, cmd_inhibit=0, cmd_complete=0, response=0, err_status=0. Reset mid-frame aborts immediately; the line is released next cycle.
- States: IDLE, SEND, WAIT_RESP, RECV, CHECK, NCC.
- IDLE:
  - cmd_start=1 latches index, arg, resp_type and check enables.
  - Next cycle: cmd_inhibit=1, cmd_oe=1, state SEND.
  - cmd_start is ignored while cmd_inhibit=1.
- SEND:
  - Frame is MSB first: 0, 1, index[5:0], arg[31:0], crc7[6:0], 1.
  - 48 bits total, one bit per sd_tick.
  - CRC7 uses polynomial x^7+x^3+1, initial value 0, computed over the first 40 bits.
  - After the end bit's tick: cmd_oe=0, cmd_pin_out=1.
  - resp_type=00: go to CHECK.
  - Otherwise: go to WAIT_RESP with the timeout counter at 0.
- WAIT_RESP:
  - Each sd_tick with cmd_pin_in=0 is the start bit; go to RECV with bit count 1.
  - Otherwise the counter increments. Reaching TIMEOUT_TICKS sets err_status[0] and goes to NCC with no cmd_complete.
- RECV:
  - Shift in on each tick until 48 or 136 bits total.
  - 48-bit: CRC over bits 47..8.
  - 136-bit: CRC over bits 127..8 of the content; the first 8 bits (start, transmission, reserved 111111) are excluded from the CRC.
- CHECK (one cycle):
  - 48-bit: response[31:0]=R[39:8], response[127:32]=0.
  - 136-bit: response[119:0]=R[127:8], response[127:120]=0.
  - Error flags set in the same cycle:
    - err[1] if crc_check_en and CRC mismatch.
    - err[2] if the end bit is 0.
    - err[3] if index_check_en, 48-bit response, and R[45:40]≠cmd_index.
  - cmd_complete pulses (also for resp_type=00). Go to NCC.
- NCC: wait NCC_TICKS ticks, then cmd_inhibit=0 and go to IDLE.
- err_status: set has priority over err_clear in the same cycle; err_clear acts only on bits not being set that cycle.
- Ticks in consecutive cycles are legal. Only a tick advances the bit or tick counters.

Decomposition:
- Package sd_cmd_pkg holds:
  - resp_type encodings RESP_NONE/136/48/48B.
  - State enum.
  - Frame lengths CMD_LEN=48, R48_LEN=48, R136_LEN=136.
  - Error bit indices ERR_TMO/CRC/END/IDX.
  - CRC7 polynomial constant.
- Sub-module sd_crc7 is a serial CRC7 with clear, enable and bit_in. It is instantiated once for TX and once for RX, or shared via clear between phases.

Test Plan:
- CMD0, arg 0x00000000, resp none -> pin carries 0x40_00000000_95 over 48 ticks; cmd_complete pulses 1 cycle after the end bit; cmd_inhibit drops after 8 further ticks; err_status=0.
- CMD8, arg 0x000001AA, resp 48 with index and CRC checks on -> TX frame 0x48_000001AA_87. Card returns 0x08_000001AA_13 -> response=0x000001AA, err_status=0.
- Same as above, but the card flips one argument bit -> err_status=4'b0010, cmd_complete still pulses; err_clear=4'b0010 clears it.
- CMD2, resp 136, card never drives a start bit -> err_status[0]=1 on the 64th post-frame tick, no cmd_complete, cmd_inhibit=0 after NCC.
- Second cmd_start mid-SEND is ignored (frame unchanged). reset=0 mid-SEND -> next cycle cmd_oe=0, cmd_pin_out=1, cmd_inhibit=0, state IDLE.
- Response index 0x09 to CMD8 with index_check_en=1 -> err_status[3]=1. With index_check_en=0 -> err_status[3]=0.

Source files
------------

// File: rtl/sd_cmd_sequencer_pkg.sv
// Shared encodings and constants for the SD command-line sequencer.
package sd_cmd_pkg;

    localparam logic [1:0] RESP_NONE = 2'b00;
    localparam logic [1:0] RESP_136  = 2'b01;
    localparam logic [1:0] RESP_48   = 2'b10;
    localparam logic [1:0] RESP_48B  = 2'b11;

    localparam int CMD_LEN  = 48;
    localparam int R48_LEN  = 48;
    localparam int R136_LEN = 136;

    localparam int ERR_TMO = 0;
    localparam int ERR_CRC = 1;
    localparam int ERR_END = 2;
    localparam int ERR_IDX = 3;

    // x^7 + x^3 + 1 with the x^7 term implied
    localparam logic [6:0] CRC7_POLY = 7'h09;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_RESP,
        RECV,
        CHECK,
        NCC
    } state_t;

endpackage

// File: rtl/sd_cmd_sequencer_if.sv
// Register-file side of the command sequencer: command request fields and status.
interface sd_cmd_sequencer_if;

    logic         cmd_start;
    logic [5:0]   cmd_index;
    logic [1:0]   resp_type;
    logic         crc_check_en;
    logic         index_check_en;
    logic [31:0]  cmd_arg;
    logic [3:0]   err_clear;
    logic         cmd_inhibit;
    logic         cmd_complete;
    logic [127:0] response;
    logic [3:0]   err_status;

    modport master (
        output cmd_start, cmd_index, resp_type, crc_check_en, index_check_en, cmd_arg, err_clear,
        input  cmd_inhibit, cmd_complete, response, err_status
    );

    modport slave (
        input  cmd_start, cmd_index, resp_type, crc_check_en, index_check_en, cmd_arg, err_clear,
        output cmd_inhibit, cmd_complete, response, err_status
    );

endinterface

// File: rtl/sd_cmd_sequencer_crc7.sv
// Serial CRC7 accumulator, MSB-first, one bit per enabled cycle.
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic feedback;

    assign feedback = bit_in ^ crc[6];

    always_ff @(posedge clock) begin
        if (!reset) begin
            crc <= '0;
        end else if (clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= {crc[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// SD host CMD-line controller: sends a 48-bit command frame, receives and checks
// the card response, and reports completion and sticky error status.
module sd_cmd_sequencer
    import sd_cmd_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 64,
    parameter int NCC_TICKS     = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic sd_tick,
    input  logic cmd_pin_in,
    output logic cmd_pin_out,
    output logic cmd_oe,
    sd_cmd_sequencer_if.slave host
);

    state_t         state, state_next;
    logic [5:0]     idx_q;
    logic [31:0]    arg_q;
    logic [1:0]     rtype_q;
    logic           crc_en_q, idx_en_q;
    logic [7:0]     bit_cnt;
    logic [15:0]    tick_cnt;
    logic [127:0]   rx_shift, response_q;
    logic [3:0]     err_q, err_set;
    logic [6:0]     tx_crc, rx_crc;
    logic [39:0]    tx_head;
    logic [7:0]     rx_len;
    logic           tx_bit, tx_crc_en, rx_crc_en, is136, is48, has_resp, start_ok;

    assign tx_head  = {2'b01, idx_q, arg_q};
    assign is136    = (rtype_q == RESP_136);
    assign is48     = (rtype_q == RESP_48) || (rtype_q == RESP_48B);
    assign has_resp = (rtype_q != RESP_NONE);
    assign rx_len   = is136 ? 8'(R136_LEN) : 8'(R48_LEN);
    assign start_ok = (state == IDLE) && host.cmd_start;

    // The start bit of a 48-bit response belongs to the CRC span; the 8-bit
    // header of a 136-bit response does not.
    assign tx_crc_en = (state == SEND) && sd_tick && (bit_cnt < 8'd40);
    assign rx_crc_en = sd_tick && (((state == WAIT_RESP) && !cmd_pin_in && !is136) ||
                       ((state == RECV) && (is136 ? ((bit_cnt >= 8'd8) && (bit_cnt < 8'd128))
                                                  : (bit_cnt < 8'd40))));

    sd_crc7 u_tx_crc (
        .clock  (clock),
        .reset  (reset),
        .clear  (start_ok),
        .enable (tx_crc_en),
        .bit_in (tx_bit),
        .crc    (tx_crc)
    );

    sd_crc7 u_rx_crc (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == SEND),
        .enable (rx_crc_en),
        .bit_in (cmd_pin_in),
        .crc    (rx_crc)
    );

    always_comb begin
        tx_bit = 1'b1;
        if (bit_cnt < 8'd40) begin
            tx_bit = tx_head[6'd39 - bit_cnt[5:0]];
        end else if (bit_cnt < 8'(CMD_LEN - 1)) begin
            tx_bit = tx_crc[3'd6 - bit_cnt[2:0]];
        end
    end

    assign cmd_oe            = (state == SEND);
    assign cmd_pin_out       = (state == SEND) ? tx_bit : 1'b1;
    assign host.cmd_inhibit  = (state != IDLE);
    assign host.cmd_complete = (state == CHECK);
    assign host.response     = response_q;
    assign host.err_status   = err_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        err_set    = '0;
        case (state)
            IDLE: begin
                if (host.cmd_start) state_next = SEND;
            end
            SEND: begin
                if (sd_tick && (bit_cnt == 8'(CMD_LEN - 1))) begin
                    state_next = has_resp ? WAIT_RESP : CHECK;
                end
            end
            WAIT_RESP: begin
                if (sd_tick) begin
                    if (!cmd_pin_in) begin
                        state_next = RECV;
                    end else if (tick_cnt == 16'(TIMEOUT_TICKS - 1)) begin
                        state_next       = NCC;
                        err_set[ERR_TMO] = 1'b1;
                    end
                end
            end
            RECV: begin
                if (sd_tick && (bit_cnt == rx_len - 8'd1)) state_next = CHECK;
            end
            CHECK: begin
                state_next = NCC;
                if (has_resp) begin
                    err_set[ERR_CRC] = crc_en_q && (rx_crc != rx_shift[7:1]);
                    err_set[ERR_END] = !rx_shift[0];
                    err_set[ERR_IDX] = idx_en_q && is48 && (rx_shift[45:40] != idx_q);
                end
            end
            NCC: begin
                if (sd_tick && (tick_cnt == 16'(NCC_TICKS - 1))) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latched command, bit/tick counters, receive shifter, status.
    always_ff @(posedge clock) begin
        if (!reset) begin
            idx_q      <= '0;
            arg_q      <= '0;
            rtype_q    <= RESP_NONE;
            crc_en_q   <= 1'b0;
            idx_en_q   <= 1'b0;
            bit_cnt    <= '0;
            tick_cnt   <= '0;
            rx_shift   <= '0;
            response_q <= '0;
            err_q      <= '0;
        end else begin
            err_q <= (err_q & ~host.err_clear) | err_set;
            if (start_ok) begin
                idx_q    <= host.cmd_index;
                arg_q    <= host.cmd_arg;
                rtype_q  <= host.resp_type;
                crc_en_q <= host.crc_check_en;
                idx_en_q <= host.index_check_en;
                bit_cnt  <= '0;
            end
            case (state)
                SEND: begin
                    if (sd_tick) begin
                        bit_cnt  <= bit_cnt + 8'd1;
                        tick_cnt <= '0;
                    end
                end
                WAIT_RESP: begin
                    if (sd_tick) begin
                        if (!cmd_pin_in) begin
                            bit_cnt  <= 8'd1;
                            rx_shift <= {rx_shift[126:0], cmd_pin_in};
                        end else if (tick_cnt == 16'(TIMEOUT_TICKS - 1)) begin
                            tick_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + 16'd1;
                        end
                    end
                end
                RECV: begin
                    if (sd_tick) begin
                        bit_cnt  <= bit_cnt + 8'd1;
                        rx_shift <= {rx_shift[126:0], cmd_pin_in};
                    end
                end
                CHECK: begin
                    tick_cnt <= '0;
                    if (has_resp) begin
                        response_q <= is136 ? {8'h00, rx_shift[127:8]} : {96'h0, rx_shift[39:8]};
                    end
                end
                NCC: begin
                    if (sd_tick) tick_cnt <= tick_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed scoreboard bench for sd_cmd_sequencer with a behavioural SD card on the CMD line.
module tb_sd_cmd_sequencer;
    import sd_cmd_pkg::*;

    typedef struct {
        logic [127:0] resp;
        logic [3:0]   err;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic sd_tick = 1'b0;
    logic cmd_pin_in = 1'b1;
    logic cmd_pin_out, cmd_oe;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tick_div = 1;
    int tick_phase = 0;
    int completes = 0;
    int complete_cyc = 0;
    int tx_end_cyc = 0;

    logic [47:0] tx_q[$];
    exp_t        rsp_q[$];

    sd_cmd_sequencer_if bus ();

    sd_cmd_sequencer #(
        .TIMEOUT_TICKS (64),
        .NCC_TICKS     (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sd_tick     (sd_tick),
        .cmd_pin_in  (cmd_pin_in),
        .cmd_pin_out (cmd_pin_out),
        .cmd_oe      (cmd_oe),
        .host        (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    initial begin
        forever begin
            @(posedge clock);
            #1;
            tick_phase++;
            sd_tick = (tick_phase % tick_div) == 0;
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [6:0] crc7_model(input logic [127:0] data, input int n);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = data[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] frame_of(input logic [7:0] head, input logic [31:0] arg);
        logic [39:0] h;
        h = {head, arg};
        return {h, crc7_model({88'h0, h}, 40), 1'b1};
    endfunction

    task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Transmit monitor: collects frame bits on each tick while the host drives CMD.
    initial begin
        logic [47:0] sh;
        int          n;
        sh = '0;
        n  = 0;
        forever begin
            @(negedge clock);
            if (cmd_oe && sd_tick) begin
                sh = {sh[46:0], cmd_pin_out};
                n++;
                if (n == 48) begin
                    tx_end_cyc = cyc;
                    check_output("tx_q_nonempty", 128'(tx_q.size() != 0), 128'd1);
                    if (tx_q.size() != 0) check_output("tx_frame", 128'(sh), 128'(tx_q.pop_front()));
                    n = 0;
                end
            end else if (!cmd_oe) begin
                n = 0;
            end
        end
    end

    // Completion monitor: status is compared the cycle after the completion pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (bus.cmd_complete) begin
                completes++;
                complete_cyc = cyc;
                @(negedge clock);
                check_output("complete_width", 128'(bus.cmd_complete), 128'd0);
                check_output("rsp_q_nonempty", 128'(rsp_q.size() != 0), 128'd1);
                if (rsp_q.size() != 0) begin
                    e = rsp_q.pop_front();
                    check_output("response", bus.response, e.resp);
                    check_output("err_status", 128'(bus.err_status), 128'(e.err));
                end
            end
        end
    end

    task automatic wait_tick_edge();
        forever begin
            @(posedge clock);
            if (sd_tick) break;
        end
        #2;
    endtask

    task automatic apply_stimulus(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                                  input logic crc_en, input logic idx_en);
        @(posedge clock);
        #2;
        bus.cmd_index      = idx;
        bus.cmd_arg        = arg;
        bus.resp_type      = rt;
        bus.crc_check_en   = crc_en;
        bus.index_check_en = idx_en;
        bus.cmd_start      = 1'b1;
        @(posedge clock);
        #2;
        bus.cmd_start = 1'b0;
    endtask

    task automatic wait_oe_low();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clock);
            if (!cmd_oe) begin
                ok = 1'b1;
                break;
            end
        end
        check_output("oe_release_wait", 128'(ok), 128'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            if (!bus.cmd_inhibit) begin
                ok = 1'b1;
                break;
            end
        end
        check_output("idle_wait", 128'(ok), 128'd1);
    endtask

    task automatic card_send(input logic [135:0] bits, input int len, input int gap);
        wait_oe_low();
        repeat (gap) wait_tick_edge();
        for (int i = len - 1; i >= 0; i--) begin
            cmd_pin_in = bits[i];
            wait_tick_edge();
        end
        cmd_pin_in = 1'b1;
    endtask

    task automatic pulse_err_clear(input logic [3:0] mask);
        @(posedge clock);
        #2;
        bus.err_clear = mask;
        @(posedge clock);
        #2;
        bus.err_clear = 4'h0;
    endtask

    initial begin
        logic [119:0] content;
        logic [135:0] long_resp;
        logic [47:0]  idx9_resp;
        int           n, c0;
        bit           ok;

        bus.cmd_start      = 1'b0;
        bus.cmd_index      = '0;
        bus.cmd_arg        = '0;
        bus.resp_type      = RESP_NONE;
        bus.crc_check_en   = 1'b0;
        bus.index_check_en = 1'b0;
        bus.err_clear      = 4'h0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_output("rst_pin_out", 128'(cmd_pin_out), 128'd1);
        check_output("rst_oe", 128'(cmd_oe), 128'd0);
        check_output("rst_inhibit", 128'(bus.cmd_inhibit), 128'd0);
        check_output("rst_complete", 128'(bus.cmd_complete), 128'd0);
        check_output("rst_response", bus.response, 128'd0);
        check_output("rst_err", 128'(bus.err_status), 128'd0);
        reset = 1'b1;

        $display("[TB] CMD0, no response, tick every 3rd cycle");
        tick_div = 3;
        tx_q.push_back(48'h40_0000_0000_95);
        rsp_q.push_back('{resp: 128'd0, err: 4'h0});
        c0 = completes;
        apply_stimulus(6'd0, 32'h0, RESP_NONE, 1'b0, 1'b0);
        check_output("start_oe", 128'(cmd_oe), 128'd1);
        check_output("start_inhibit", 128'(bus.cmd_inhibit), 128'd1);
        ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clock);
            #3;
            if (completes != c0) begin
                ok = 1'b1;
                break;
            end
        end
        check_output("cmd0_complete_wait", 128'(ok), 128'd1);
        check_output("complete_latency", 128'(complete_cyc - tx_end_cyc), 128'd1);
        n = 0;
        for (int k = 0; k < 500; k++) begin
            @(posedge clock);
            if (sd_tick) n++;
            #2;
            if (!bus.cmd_inhibit) break;
        end
        check_output("ncc_ticks", 128'(n), 128'd8);

        $display("[TB] CMD8 R7 with CRC and index checks");
        tick_div = 1;
        tx_q.push_back(48'h48_0000_01AA_87);
        rsp_q.push_back('{resp: 128'h1AA, err: 4'h0});
        apply_stimulus(6'd8, 32'h0000_01AA, RESP_48, 1'b1, 1'b1);
        card_send(136'(48'h08_0000_01AA_13), 48, 3);
        wait_idle();

        $display("[TB] CMD8 with a flipped argument bit");
        tx_q.push_back(48'h48_0000_01AA_87);
        rsp_q.push_back('{resp: 128'h1AB, err: 4'b0010});
        apply_stimulus(6'd8, 32'h0000_01AA, RESP_48, 1'b1, 1'b1);
        card_send(136'(48'h08_0000_01AB_13), 48, 0);
        wait_idle();
        pulse_err_clear(4'b0010);
        check_output("err_cleared_crc", 128'(bus.err_status), 128'd0);

        $display("[TB] CMD8 answered with index 9");
        idx9_resp = frame_of(8'h09, 32'h0000_01AA);
        tx_q.push_back(48'h48_0000_01AA_87);
        rsp_q.push_back('{resp: 128'h1AA, err: 4'b1000});
        apply_stimulus(6'd8, 32'h0000_01AA, RESP_48, 1'b1, 1'b1);
        card_send(136'(idx9_resp), 48, 5);
        wait_idle();
        pulse_err_clear(4'hF);
        tx_q.push_back(48'h48_0000_01AA_87);
        rsp_q.push_back('{resp: 128'h1AA, err: 4'b0000});
        apply_stimulus(6'd8, 32'h0000_01AA, RESP_48, 1'b1, 1'b0);
        card_send(136'(idx9_resp), 48, 2);
        wait_idle();

        $display("[TB] CMD2 with no card answer");
        tx_q.push_back(frame_of(8'h42, 32'h0));
        c0 = completes;
        apply_stimulus(6'd2, 32'h0, RESP_136, 1'b1, 1'b0);
        wait_oe_low();
        check_output("tmo_not_early", 128'(bus.err_status), 128'd0);
        n = 0;
        for (int k = 0; k < 500; k++) begin
            @(posedge clock);
            if (sd_tick) n++;
            #2;
            if (bus.err_status[ERR_TMO]) break;
        end
        check_output("timeout_ticks", 128'(n), 128'd64);
        wait_idle();
        check_output("timeout_no_complete", 128'(completes - c0), 128'd0);
        check_output("timeout_err", 128'(bus.err_status), 128'd1);
        pulse_err_clear(4'b0001);

        $display("[TB] CMD2 with a 136-bit answer, tick every 2nd cycle");
        tick_div = 2;
        content = 120'h0123456789ABCDEFFEDCBA98765432;
        long_resp = {2'b00, 6'b111111, content, crc7_model({8'h00, content}, 120), 1'b1};
        tx_q.push_back(frame_of(8'h42, 32'h0));
        rsp_q.push_back('{resp: {8'h00, content}, err: 4'h0});
        apply_stimulus(6'd2, 32'h0, RESP_136, 1'b1, 1'b0);
        card_send(long_resp, 136, 4);
        wait_idle();

        $display("[TB] second start during SEND");
        tick_div = 1;
        tx_q.push_back(frame_of(8'h51, 32'h1234_5678));
        rsp_q.push_back('{resp: {8'h00, content}, err: 4'h0});
        apply_stimulus(6'd17, 32'h1234_5678, RESP_NONE, 1'b0, 1'b0);
        repeat (10) wait_tick_edge();
        apply_stimulus(6'd55, 32'hFFFF_FFFF, RESP_48, 1'b1, 1'b1);
        wait_idle();

        $display("[TB] reset during SEND");
        apply_stimulus(6'd24, 32'hA5A5_A5A5, RESP_48, 1'b1, 1'b1);
        repeat (20) wait_tick_edge();
        @(posedge clock);
        #2;
        reset = 1'b0;
        @(posedge clock);
        #2;
        check_output("abort_oe", 128'(cmd_oe), 128'd0);
        check_output("abort_pin_out", 128'(cmd_pin_out), 128'd1);
        check_output("abort_inhibit", 128'(bus.cmd_inhibit), 128'd0);
        check_output("abort_response", bus.response, 128'd0);
        reset = 1'b1;
        repeat (5) @(posedge clock);

        check_output("tx_q_drained", 128'(tx_q.size()), 128'd0);
        check_output("rsp_q_drained", 128'(rsp_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
